// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES block constants and round-stage FSM encodings
// Purpose: widths and state encodings shared by the SubBytes and InvSubBytes stages.
// Ports: none (package).
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SUB  = 2'b01,
    ST_DONE = 2'b10
  } aes_stage_state_t;

endpackage

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - combinational AES inverse S-box (FIPS-197 table)
// Purpose: maps one byte to its inverse S-box value; standalone and exhaustively checkable.
// Ports:
//   data    in   8   byte to substitute
//   result  out  8   inverse S-box of data
module inv_sbox (
  input  logic [7:0] data,
  output logic [7:0] result
);

  // Entry 0 sits in the top byte, entry 255 in the bottom byte.
  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] bit_hi;

  assign bit_hi = 11'd2047 - {data, 3'b000};
  assign result = INV_SBOX_TABLE[bit_hi -: 8];

endmodule

// File: rtl/inv_sub_bytes.sv
// rtl/inv_sub_bytes.sv - iterative AES InvSubBytes stage with En/Ry handshake
// Purpose: substitutes all 16 state bytes with inverse S-box values, BYTES_PER_CYCLE per clock,
//          most significant byte group first.
// Ports:
//   Clk      in   1    clock, rising edge
//   Rst      in   1    asynchronous active-low reset
//   En_ISB   in   1    request; hold high until Ry_ISB, drop to abort or release
//   In_ISB   in   128  input state, captured on IDLE->SUB only
//   Ry_ISB   out  1    Out_ISB valid and stable while high
//   Out_ISB  out  128  substituted state (registered)
module inv_sub_bytes
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         En_ISB,
  input  logic [127:0] In_ISB,
  output logic         Ry_ISB,
  output logic [127:0] Out_ISB
);

  localparam int N  = AES_BYTES / BYTES_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = 8 * BYTES_PER_CYCLE;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
      BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bytes_per_cycle
    $error("inv_sub_bytes: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  aes_stage_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [127:0]     work_q, work_d;
  logic [127:0]     work_sub;
  logic             ry_q, ry_d;
  logic [127:0]     out_q, out_d;

  // Group table is padded to a power of two so cnt_q always indexes in range.
  logic [GW-1:0] groups [2**CW];
  logic [GW-1:0] grp_in;
  logic [GW-1:0] grp_out;

  for (genvar k = 0; k < 2**CW; k++) begin : g_groups
    if (k < N) begin : g_real
      assign groups[k] = work_q[AES_BLOCK_W-1-k*GW -: GW];
      // Work register with the current group replaced by its substituted bytes.
      assign work_sub[AES_BLOCK_W-1-k*GW -: GW] =
        (cnt_q == CW'(k)) ? grp_out : work_q[AES_BLOCK_W-1-k*GW -: GW];
    end else begin : g_pad
      assign groups[k] = '0;
    end
  end

  assign grp_in = groups[cnt_q];

  for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .data   (grp_in[8*i +: 8]),
      .result (grp_out[8*i +: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    ry_d    = ry_q;
    out_d   = out_q;
    unique case (state_q)
      ST_IDLE: begin
        ry_d = 1'b0;
        if (En_ISB) begin
          work_d  = In_ISB;
          cnt_d   = '0;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        if (!En_ISB) begin
          // Abort: Out_ISB keeps the previous complete result.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          work_d = work_sub;
          if (cnt_q == CNT_LAST) begin
            out_d   = work_sub;
            ry_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        // En held high keeps us here; a new op needs En low for one edge.
        if (!En_ISB) begin
          ry_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        ry_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      ry_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      ry_q    <= ry_d;
      out_q   <= out_d;
    end
  end

  assign Ry_ISB  = ry_q;
  assign Out_ISB = out_q;

endmodule
